// File: rtl/fnn_pkg.sv
// fnn_pkg: shared fixed-point constants, neuron state type and accumulator sizing.
package fnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 12;

    typedef enum logic [1:0] {ACCUM, DRAIN, FINAL} neuron_state_e;

    // Wide enough that numWeight full-scale products can never overflow.
    function automatic int acc_width(input int n_weight, input int data_width = DATA_WIDTH);
        return 2 * data_width + $clog2(n_weight);
    endfunction

endpackage

// File: rtl/fx_round_sat.sv
// fx_round_sat: round half-up, drop FRAC fraction bits and saturate a wide signed value to OUT_W.
module fx_round_sat #(
    parameter int IN_W  = 38,
    parameter int OUT_W = 16,
    parameter int FRAC  = 12
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    localparam logic signed [IN_W:0] MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN = ~MAX;

    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] shr;

    assign rnd  = $signed({din[IN_W-1], din}) + $signed((IN_W+1)'(1) << (FRAC-1));
    assign shr  = rnd >>> FRAC;
    assign dout = shr > MAX ? MAX[OUT_W-1:0] : shr < MIN ? MIN[OUT_W-1:0] : shr[OUT_W-1:0];

endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: serial MAC neuron driving its weight ROM, adds bias, rounds and saturates.
// Define NEURON_RELU_EN to clamp negative results to zero.
module neuron_mac_seq
    import fnn_pkg::*;
#(
    parameter int numWeight    = 30,
    parameter int addressWidth = $clog2(numWeight),
    parameter int dataWidth    = DATA_WIDTH,
    parameter int fracBits     = FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [dataWidth-1:0]    in_data,
    input  logic [dataWidth-1:0]    bias,
    output logic                    w_ren,
    output logic [addressWidth-1:0] w_radd,
    input  logic [dataWidth-1:0]    w_data,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data
);

    localparam int ACC_W = acc_width(numWeight, dataWidth);
    localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);

    neuron_state_e               state_q, state_d;
    logic [addressWidth-1:0]     cnt_q, cnt_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [dataWidth-1:0] in_d_q, in_d_d;
    logic                        mac_en_q, mac_en_d;
    logic                        out_valid_q, out_valid_d;
    logic [dataWidth-1:0]        out_data_q, out_data_d;

    logic                          accept;
    logic signed [2*dataWidth-1:0] prod;
    logic signed [ACC_W:0]         sum;
    logic [dataWidth-1:0]          sat;
    logic [dataWidth-1:0]          res;

    assign in_ready  = (state_q == ACCUM) & ~rst;
    assign accept    = in_valid & in_ready;
    assign w_ren     = accept;
    assign w_radd    = cnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // The weight arrives one cycle after its address, so the activation is delayed to meet it.
    assign prod = in_d_q * $signed(w_data);
    assign sum  = (ACC_W+1)'(acc_q) + ((ACC_W+1)'($signed(bias)) <<< fracBits);

    fx_round_sat #(
        .IN_W (ACC_W + 1),
        .OUT_W(dataWidth),
        .FRAC (fracBits)
    ) u_round_sat (
        .din (sum),
        .dout(sat)
    );

`ifdef NEURON_RELU_EN
    assign res = sat[dataWidth-1] ? '0 : sat;
`else
    assign res = sat;
`endif

    always_comb begin
        cnt_d       = accept ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
        in_d_d      = accept ? $signed(in_data) : in_d_q;
        mac_en_d    = accept;
        acc_d       = state_q == FINAL ? '0 : mac_en_q ? acc_q + ACC_W'(prod) : acc_q;
        state_d     = state_q == DRAIN ? FINAL :
                      state_q == FINAL ? ACCUM :
                      (accept && cnt_q == LAST) ? DRAIN : state_q;
        out_valid_d = state_q == FINAL;
        out_data_d  = state_q == FINAL ? res : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            in_d_q      <= '0;
            mac_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            in_d_q      <= in_d_d;
            mac_en_q    <= mac_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: scoreboard bench for a 3-weight and a 30-weight neuron instance.
module tb_neuron_mac_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv [2];
    logic [15:0] id [2];
    logic [15:0] bs [2];
    logic [15:0] wd [2];
    logic [15:0] od [2];
    logic [15:0] od0, od1;
    logic [1:0]  rdy, wren, ov;
    logic [1:0]  ra3;
    logic [4:0]  ra30;
    logic [4:0]  ra [2];
    logic [15:0] rom [2][30];

    assign ra[0] = {3'b000, ra3};
    assign ra[1] = ra30;
    assign od[0] = od0;
    assign od[1] = od1;

    neuron_mac_seq #(.numWeight(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0]),
        .bias(bs[0]), .w_ren(wren[0]), .w_radd(ra3), .w_data(wd[0]),
        .out_valid(ov[0]), .out_data(od0)
    );

    neuron_mac_seq #(.numWeight(30)) u30 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1]),
        .bias(bs[1]), .w_ren(wren[1]), .w_radd(ra30), .w_data(wd[1]),
        .out_valid(ov[1]), .out_data(od1)
    );

    always @(posedge clk) begin
        if (wren[0]) wd[0] <= rom[0][ra[0]];
        if (wren[1]) wd[1] <= rom[1][ra[1]];
    end

    typedef struct {
        logic [15:0] d;
        time         t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   sz;
        for (int k = 0; k < 2; k++) begin
            if (ov[k]) begin
                sz = (k == 0) ? q0.size() : q1.size();
                chk($sformatf("out_expected_u%0d", k), 64'(sz != 0), 64'(1));
                if (sz != 0) begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("out_data_u%0d", k), 64'(od[k]), 64'(e.d));
                    chk($sformatf("latency_u%0d", k), 64'($time), 64'(e.t));
                end
            end
        end
    end

    task automatic frame(input int k, input int n, input logic [15:0] xs [30], input bit gaps,
                         output time tfirst, output time tlast);
        for (int i = 0; i < n; i++) begin
            int g;
            int w;
            g = (gaps && i > 0) ? int'($urandom_range(1)) : 0;
            repeat (g) begin
                iv[k] = 1'b0;
                @(negedge clk);
                chk("w_ren_idle", 64'(wren[k]), 64'(0));
                @(posedge clk);
                #1;
            end
            iv[k] = 1'b1;
            id[k] = xs[i];
            @(negedge clk);
            w = 0;
            while (!rdy[k] && w < 8) begin
                @(negedge clk);
                w++;
            end
            chk("in_ready_wait", 64'(rdy[k]), 64'(1));
            chk("w_ren_accept", 64'(wren[k]), 64'(1));
            chk("w_radd", 64'(ra[k]), 64'(i));
            @(posedge clk);
            if (i == 0) tfirst = $time;
            tlast = $time;
            #1;
            iv[k] = 1'b0;
        end
    endtask

    task automatic push(input int k, input logic [15:0] d, input time tl);
        exp_t e;
        e.d = d;
        e.t = tl + 25;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] xs [30];
        time tf, tl, tl_prev;
        logic [15:0] neg_exp;
        logic [15:0] min_exp;
`ifdef NEURON_RELU_EN
        neg_exp = 16'h0000;
        min_exp = 16'h0000;
`else
        neg_exp = 16'hE800;
        min_exp = 16'h8000;
`endif
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            id[k] = '0;
            bs[k] = '0;
        end
        for (int i = 0; i < 30; i++) begin
            rom[0][i] = 16'h0800;
            rom[1][i] = 16'h7FFF;
            xs[i]     = '0;
        end
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) chk("in_ready_in_reset", 64'(rdy[k]), 64'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_out_valid", 64'(ov[k]), 64'(0));
            chk("reset_out_data", 64'(od[k]), 64'(0));
            chk("reset_in_ready", 64'(rdy[k]), 64'(1));
        end
        @(posedge clk);
        #1;

        // 3 x (1.0 * 0.5) + 0.25 = 1.75
        bs[0] = 16'h0400;
        for (int i = 0; i < 3; i++) xs[i] = 16'h1000;
        frame(0, 3, xs, 1'b0, tf, tl);
        push(0, 16'h1C00, tl);
        idle(6);

        bs[0] = 16'h0000;
        for (int i = 0; i < 3; i++) xs[i] = 16'hF000;
        frame(0, 3, xs, 1'b0, tf, tl);
        push(0, neg_exp, tl);
        idle(6);

        // exact half LSB rounds up; negative half rounds up to zero
        xs[0] = 16'h0001; xs[1] = 16'h0000; xs[2] = 16'h0000;
        frame(0, 3, xs, 1'b0, tf, tl);
        push(0, 16'h0001, tl);
        idle(6);
        xs[0] = 16'hFFFF;
        frame(0, 3, xs, 1'b0, tf, tl);
        push(0, 16'h0000, tl);
        idle(6);

        // back-to-back frames with random bubbles: 0.5+1-1+0.0625, then half-LSB+0.0625
        bs[0] = 16'h0100;
        xs[0] = 16'h1000; xs[1] = 16'h2000; xs[2] = 16'hE000;
        frame(0, 3, xs, 1'b1, tf, tl);
        push(0, 16'h0900, tl);
        tl_prev = tl;
        xs[0] = 16'h0001; xs[1] = 16'h0000; xs[2] = 16'h0000;
        frame(0, 3, xs, 1'b1, tf, tl);
        push(0, 16'h0101, tl);
        chk("b2b_first_accept_in_out_valid_cycle", 64'(tf), 64'(tl_prev + 30));
        idle(6);

        bs[1] = 16'h7FFF;
        for (int i = 0; i < 30; i++) xs[i] = 16'h7FFF;
        frame(1, 30, xs, 1'b0, tf, tl);
        push(1, 16'h7FFF, tl);
        idle(6);

        bs[1] = 16'h0000;
        for (int i = 0; i < 30; i++) xs[i] = 16'h8000;
        frame(1, 30, xs, 1'b0, tf, tl);
        push(1, min_exp, tl);
        idle(6);

        // abort after 17 accepts; nothing may come out of the partial frame
        for (int i = 0; i < 30; i++) xs[i] = 16'h1000;
        frame(1, 17, xs, 1'b0, tf, tl);
        iv[1] = 1'b1;
        id[1] = 16'h1000;
        rst   = 1'b1;
        @(negedge clk);
        chk("w_ren_in_reset", 64'(wren[1]), 64'(0));
        chk("in_ready_in_reset_mid", 64'(rdy[1]), 64'(0));
        @(posedge clk);
        #1;
        rst   = 1'b0;
        iv[1] = 1'b0;
        idle(4);

        // 30 x (16 * 32767) / 4096 rounds to 3840
        for (int i = 0; i < 30; i++) xs[i] = 16'h0010;
        frame(1, 30, xs, 1'b0, tf, tl);
        push(1, 16'h0F00, tl);
        idle(10);

        chk("queue0_drained", 64'(q0.size()), 64'(0));
        chk("queue1_drained", 64'(q1.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
